// File: rtl/dvi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dvi_pkg
//  Purpose  : Shared constants and helpers for the DVI TMDS encoder: the four
//             control tokens, the pipeline latency, the default width of the
//             disparity counter and an 8-bit population count.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package dvi_pkg;

  localparam int TMDS_LATENCY      = 3;
  localparam int DEFAULT_CNT_WIDTH = 5;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dvi_tmds_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : dvi_tmds_encoder_if
//  Purpose  : Pixel-side bundle of one TMDS channel.
//  Signals  : din[7:0] colour component, c0/c1 control bits, de data enable,
//             dout[9:0] TMDS symbol (bit 0 sent first).
//  Modports : master = video timing driver, slave = encoder.
//  Revision : 1.0  initial release
// ============================================================================
interface dvi_tmds_encoder_if;
  logic [7:0] din;
  logic       c0;
  logic       c1;
  logic       de;
  logic [9:0] dout;

  modport master (output din, output c0, output c1, output de, input dout);
  modport slave  (input din, input c0, input c1, input de, output dout);
endinterface
`default_nettype wire

// File: rtl/tmds_qm_encode.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_qm_encode
//  Purpose  : First two pipeline stages of the TMDS encoder. Stage 1 registers
//             the inputs with the popcount of din; stage 2 registers the
//             transition-minimised word q_m and its ones/zeros counts.
//  Ports    : pixel_clk, reset (sync, active-high)
//             din_i/de_i/c0_i/c1_i      -> raw pixel inputs
//             q_m_o/n1_qm_o/n0_qm_o     <- minimised word and its balance
//             de_o/c0_o/c1_o            <- controls delayed by two cycles
//  Revision : 1.0  initial release
// ============================================================================
module tmds_qm_encode
  import dvi_pkg::*;
(
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic [7:0] din_i,
  input  logic       de_i,
  input  logic       c0_i,
  input  logic       c1_i,
  output logic [8:0] q_m_o,
  output logic [3:0] n1_qm_o,
  output logic [3:0] n0_qm_o,
  output logic       de_o,
  output logic       c0_o,
  output logic       c1_o
);

  // Stage 1
  logic [7:0] din_q;
  logic [3:0] n1_din_q;
  logic       de1_q, c0_1_q, c1_1_q;

  // Stage 2
  logic [8:0] q_m_q, q_m_d;
  logic [3:0] n1_qm_q, n1_qm_d;
  logic [3:0] n0_qm_q, n0_qm_d;
  logic       de2_q, c0_2_q, c1_2_q;

  logic use_xnor;
  logic acc;

  // XNOR chaining is chosen when the byte is ones-heavy, which keeps the
  // number of transitions in q_m low.
  assign use_xnor = (n1_din_q > 4'd4) || ((n1_din_q == 4'd4) && !din_q[0]);

  always_comb begin
    q_m_d    = '0;
    acc      = din_q[0];
    q_m_d[0] = din_q[0];
    for (int i = 1; i < 8; i++) begin
      acc      = use_xnor ? ~(acc ^ din_q[i]) : (acc ^ din_q[i]);
      q_m_d[i] = acc;
    end
    q_m_d[8] = ~use_xnor;
    n1_qm_d  = popcount8(q_m_d[7:0]);
    n0_qm_d  = 4'd8 - n1_qm_d;
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      din_q    <= '0;
      n1_din_q <= '0;
      de1_q    <= 1'b0;
      c0_1_q   <= 1'b0;
      c1_1_q   <= 1'b0;
      q_m_q    <= '0;
      n1_qm_q  <= '0;
      n0_qm_q  <= '0;
      de2_q    <= 1'b0;
      c0_2_q   <= 1'b0;
      c1_2_q   <= 1'b0;
    end else begin
      din_q    <= din_i;
      n1_din_q <= popcount8(din_i);
      de1_q    <= de_i;
      c0_1_q   <= c0_i;
      c1_1_q   <= c1_i;
      q_m_q    <= q_m_d;
      n1_qm_q  <= n1_qm_d;
      n0_qm_q  <= n0_qm_d;
      de2_q    <= de1_q;
      c0_2_q   <= c0_1_q;
      c1_2_q   <= c1_1_q;
    end
  end

  assign q_m_o   = q_m_q;
  assign n1_qm_o = n1_qm_q;
  assign n0_qm_o = n0_qm_q;
  assign de_o    = de2_q;
  assign c0_o    = c0_2_q;
  assign c1_o    = c1_2_q;

endmodule
`default_nettype wire

// File: rtl/dvi_tmds_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : dvi_tmds_encoder
//  Purpose  : One DVI TMDS 8b/10b channel encoder. Three-stage pipeline; the
//             last stage selects the symbol polarity from the running
//             disparity and emits control tokens during blanking.
//  Ports    : pixel_clk        pixel clock
//             reset            synchronous, active-high
//             bus (slave)      din/c0/c1/de in, dout[9:0] out
//  Params   : CNT_WIDTH        width of the signed running-disparity counter
//  Revision : 1.0  initial release
// ============================================================================
module dvi_tmds_encoder
  import dvi_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic               pixel_clk,
  input  logic               reset,
  dvi_tmds_encoder_if.slave  bus
);

  logic [8:0] q_m;
  logic [3:0] n1_qm, n0_qm;
  logic       de_s2, c0_s2, c1_s2;

  tmds_qm_encode u_qm (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .din_i     (bus.din),
    .de_i      (bus.de),
    .c0_i      (bus.c0),
    .c1_i      (bus.c1),
    .q_m_o     (q_m),
    .n1_qm_o   (n1_qm),
    .n0_qm_o   (n0_qm),
    .de_o      (de_s2),
    .c0_o      (c0_s2),
    .c1_o      (c1_s2)
  );

  logic [9:0]                  dout_q, dout_d;
  logic signed [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic signed [CNT_WIDTH-1:0] n1_s, n0_s, two_q8, two_nq8;
  logic                        cnt_zero, cnt_pos, cnt_neg;

  always_comb begin
    n1_s     = $signed(CNT_WIDTH'(n1_qm));
    n0_s     = $signed(CNT_WIDTH'(n0_qm));
    two_q8   = q_m[8] ? $signed(CNT_WIDTH'(2)) : '0;
    two_nq8  = q_m[8] ? '0 : $signed(CNT_WIDTH'(2));
    cnt_zero = (cnt_q == '0);
    cnt_neg  = cnt_q[CNT_WIDTH-1];
    cnt_pos  = !cnt_zero && !cnt_neg;

    dout_d = CTRL_TOKEN_00;
    cnt_d  = cnt_q;

    if (!de_s2) begin
      // Blanking: token by {c1,c0}; the next active run starts balanced.
      cnt_d = '0;
      case ({c1_s2, c0_s2})
        2'b00:   dout_d = CTRL_TOKEN_00;
        2'b01:   dout_d = CTRL_TOKEN_01;
        2'b10:   dout_d = CTRL_TOKEN_10;
        default: dout_d = CTRL_TOKEN_11;
      endcase
    end else if (cnt_zero || (n1_qm == n0_qm)) begin
      // No bias to correct: q_m[8] alone decides inversion.
      dout_d = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      cnt_d  = q_m[8] ? cnt_q + (n1_s - n0_s) : cnt_q + (n0_s - n1_s);
    end else if ((cnt_pos && (n1_qm > n0_qm)) || (cnt_neg && (n0_qm > n1_qm))) begin
      // Word would push disparity further the same way: invert it.
      dout_d = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_d  = cnt_q + two_q8 + (n0_s - n1_s);
    end else begin
      dout_d = {1'b0, q_m[8], q_m[7:0]};
      cnt_d  = cnt_q - two_nq8 + (n1_s - n0_s);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      dout_q <= '0;
      cnt_q  <= '0;
    end else begin
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.dout = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_dvi_tmds_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dvi_tmds_encoder
//  Purpose  : Self-checking bench for dvi_tmds_encoder: a fixed vector table
//             for reset, tokens and the data corner cases, then random
//             traffic (with occasional resets) against a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dvi_tmds_encoder;

  logic pixel_clk = 1'b0;
  logic reset     = 1'b1;

  always #5 pixel_clk = ~pixel_clk;

  dvi_tmds_encoder_if bus ();

  dvi_tmds_encoder #(.CNT_WIDTH(5)) dut (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int step, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s step %0d: got 0x%0h (%0d) required 0x%0h (%0d)", name, step, got, got, want, want);
    end
  endtask

  task automatic check_bound(input string name, input int step, input int v, input int lim);
    n_cmp++;
    if (v > lim || v < -lim) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0d required within +/-%0d", name, step, v, lim);
    end
  endtask

  // ---------------- fixed vectors ----------------
  typedef struct {
    bit       rst;
    bit       de;
    bit [1:0] c;
    bit [7:0] din;
    bit [9:0] exp_dout;
    int       exp_cnt;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  function automatic vec_t mk(bit rst, bit de, bit [1:0] c, bit [7:0] din, bit [9:0] e, int ec);
    vec_t v;
    v.rst = rst; v.de = de; v.c = c; v.din = din; v.exp_dout = e; v.exp_cnt = ec;
    return v;
  endfunction

  // ---------------- reference model ----------------
  logic [9:0] tokens [4];
  int         mdisp;
  logic [9:0] s1_sym, s2_sym, out_sym;
  bit         s1_de, s2_de, out_de;
  int         run_disp;

  // Encodes one pixel, choosing the polarity from the running disparity of
  // the emitted 10-bit stream, and updates that disparity from the symbol.
  function automatic logic [9:0] ref_encode(input logic [7:0] d, input bit de, input logic [1:0] c);
    logic [8:0] qm;
    bit         xn, inv;
    int         ones, bal;
    logic [9:0] sym;
    if (!de) begin
      mdisp = 0;
      return tokens[c];
    end
    ones  = $countones(d);
    xn    = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~xn;
    bal   = 2 * $countones(qm[7:0]) - 8;
    if (mdisp == 0 || bal == 0) inv = ~qm[8];
    else                        inv = (mdisp > 0 && bal > 0) || (mdisp < 0 && bal < 0);
    sym   = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    mdisp = mdisp + 2 * $countones(sym) - 10;
    return sym;
  endfunction

  int step_no = 0;

  task automatic model_step(input bit rst, input bit de, input logic [1:0] c, input logic [7:0] d);
    bus.de  = de;
    bus.c0  = c[0];
    bus.c1  = c[1];
    bus.din = d;
    reset   = rst;
    if (rst) begin
      out_sym = 10'h000; out_de = 1'b0;
      s2_sym  = tokens[0]; s2_de = 1'b0;
      s1_sym  = tokens[0]; s1_de = 1'b0;
      mdisp   = 0;
    end else begin
      out_sym = s2_sym; out_de = s2_de;
      s2_sym  = s1_sym; s2_de  = s1_de;
      s1_sym  = ref_encode(d, de, c); s1_de = de;
    end
    @(posedge pixel_clk);
    #1;
    check("rand_dout", step_no, int'(bus.dout), int'(out_sym));
    check_bound("cnt_range", step_no, int'(dut.cnt_q), 8);
    if (out_de) begin
      run_disp = run_disp + 2 * $countones(bus.dout) - 10;
      check_bound("run_disparity", step_no, run_disp, 8);
    end else begin
      run_disp = 0;
    end
    step_no++;
  endtask

  initial begin
    tokens[0] = 10'h354; tokens[1] = 10'h0AB; tokens[2] = 10'h154; tokens[3] = 10'h2AB;
    run_disp = 0;
    mdisp    = 0;

    //              rst de  c      din     dout     cnt
    vecs[0]  = mk(1, 0, 2'b00, 8'h00, 10'h000, 0);
    vecs[1]  = mk(1, 0, 2'b00, 8'h00, 10'h000, 0);
    vecs[2]  = mk(0, 0, 2'b00, 8'h00, 10'h354, 0);
    vecs[3]  = mk(0, 0, 2'b01, 8'h00, 10'h354, 0);
    vecs[4]  = mk(0, 0, 2'b10, 8'h00, 10'h354, 0);
    vecs[5]  = mk(0, 0, 2'b11, 8'h00, 10'h0AB, 0);
    vecs[6]  = mk(0, 1, 2'b00, 8'h00, 10'h154, 0);
    vecs[7]  = mk(0, 1, 2'b00, 8'h00, 10'h2AB, 0);
    vecs[8]  = mk(0, 1, 2'b00, 8'h00, 10'h100, -8);
    vecs[9]  = mk(0, 0, 2'b00, 8'h00, 10'h3FF, 2);
    vecs[10] = mk(0, 1, 2'b00, 8'hFF, 10'h100, -6);
    vecs[11] = mk(0, 0, 2'b00, 8'h00, 10'h354, 0);
    vecs[12] = mk(0, 1, 2'b00, 8'hFF, 10'h200, -8);
    vecs[13] = mk(0, 1, 2'b00, 8'hFF, 10'h354, 0);
    vecs[14] = mk(0, 0, 2'b00, 8'h00, 10'h200, -8);
    vecs[15] = mk(0, 0, 2'b00, 8'h00, 10'h0FF, -2);
    vecs[16] = mk(0, 0, 2'b00, 8'h00, 10'h354, 0);

    for (int i = 0; i < NVEC; i++) begin
      reset   = vecs[i].rst;
      bus.de  = vecs[i].de;
      bus.c0  = vecs[i].c[0];
      bus.c1  = vecs[i].c[1];
      bus.din = vecs[i].din;
      @(posedge pixel_clk);
      #1;
      check("vec_dout", i, int'(bus.dout), int'(vecs[i].exp_dout));
      check("vec_cnt", i, int'(dut.cnt_q), vecs[i].exp_cnt);
    end

    // Re-synchronise the model with a reset, then run random traffic.
    model_step(1, 0, 2'b00, 8'h00);
    model_step(1, 0, 2'b00, 8'h00);

    // Reset in the middle of an active line.
    for (int i = 0; i < 10; i++) model_step(0, 1, 2'b00, 8'($urandom));
    model_step(1, 1, 2'b00, 8'($urandom));
    check("midline_reset_dout", step_no, int'(bus.dout), 0);
    for (int i = 0; i < 10; i++) model_step(0, 1, 2'b00, 8'($urandom));

    for (int i = 0; i < 20000; i++) begin
      bit         r_rst;
      bit         r_de;
      logic [1:0] r_c;
      r_rst = ($urandom_range(0, 1999) == 0);
      r_de  = ($urandom_range(0, 99) < 80);
      r_c   = 2'($urandom);
      model_step(r_rst, r_de, r_c, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
